// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
// Holds the state encoding, request priority encoding and counter widths.
package pipe_ctrl_pkg;

  localparam int FLUSH_CYC_DEF = 2;
  localparam int DRAIN_CYC_DEF = 3;
  localparam int MWAIT_MAX_DEF = 15;
  localparam int SEQ_CW        = 2;
  localparam int MCNT_W        = 4;

  typedef enum logic [2:0] {
    ST_HALT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_LDSTL = 3'd2,
    ST_MWAIT = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    REQ_NONE = 3'd0,
    REQ_STOP = 3'd1,
    REQ_TRAP = 3'd2,
    REQ_JMP  = 3'd3,
    REQ_MEM  = 3'd4,
    REQ_LD   = 3'd5
  } req_t;

  // Highest-priority request wins; the rest are level inputs and get re-seen later.
  function automatic req_t prio_req(input logic stop, input logic trap, input logic jmp,
                                    input logic mem, input logic ld);
    if (stop) return REQ_STOP;
    if (trap) return REQ_TRAP;
    if (jmp)  return REQ_JMP;
    if (mem)  return REQ_MEM;
    if (ld)   return REQ_LD;
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/redirect requests into the sequencer and pipeline control back out.
interface pipe_ctrl_if;
  logic cpu_start;
  logic cpu_stop;
  logic stall_ld;
  logic mem_wait;
  logic jmp_taken_ex;
  logic trap_req;
  logic stall;
  logic stall_fe;
  logic bubble_ex;
  logic rst_pipe;
  logic pc_redirect;
  logic trap_ack;
  logic mem_tmo;
  logic cpu_running;

  modport master (
    input  cpu_start, cpu_stop, stall_ld, mem_wait, jmp_taken_ex, trap_req,
    output stall, stall_fe, bubble_ex, rst_pipe, pc_redirect, trap_ack, mem_tmo, cpu_running
  );

  modport slave (
    output cpu_start, cpu_stop, stall_ld, mem_wait, jmp_taken_ex, trap_req,
    input  stall, stall_fe, bubble_ex, rst_pipe, pc_redirect, trap_ack, mem_tmo, cpu_running
  );
endinterface

// File: rtl/pipe_ctrl_seq_cnt.sv
// Loadable down-counter with zero flag and freeze, shared by FLUSH and DRAIN.
module pc_seq_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  input  logic         freeze,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && !freeze && (cnt != '0))
      cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates hazard and redirect
// requests and drives stall, front-end stall, EX bubble and pipe flush.
//
//  state | meaning
//  HALT  | debug halted, whole pipe frozen
//  RUN   | normal issue, requests arbitrated by priority
//  LDSTL | one cycle after a load-use bubble, load now in MA
//  MWAIT | data memory wait, pipe frozen, timeout counter running
//  FLUSH | remaining rst_pipe cycles after a taken jump
//  DRAIN | no new issue while EX..WB retire, then trap redirect
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC = FLUSH_CYC_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int MWAIT_MAX = MWAIT_MAX_DEF
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.master bus
);

  state_t              state, state_nxt;
  req_t                req;
  logic [MCNT_W-1:0]   mcnt, mcnt_nxt, mcnt_inc;
  logic                stop_pend, stop_pend_nxt;
  logic                seq_load, seq_dec, seq_freeze, seq_zero;
  logic [SEQ_CW-1:0]   seq_load_val, seq_cnt;
  logic                stall, stall_fe, bubble_ex, rst_pipe;
  logic                pc_redirect, trap_ack, mem_tmo;

  assign req      = prio_req(bus.cpu_stop, bus.trap_req, bus.jmp_taken_ex,
                             bus.mem_wait, bus.stall_ld);
  assign mcnt_inc = (mcnt == '1) ? mcnt : mcnt + MCNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HALT;
      mcnt      <= '0;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      mcnt      <= mcnt_nxt;
      stop_pend <= stop_pend_nxt;
    end
  end

  pc_seq_cnt #(.W(SEQ_CW)) u_seq_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seq_load),
    .load_val (seq_load_val),
    .dec      (seq_dec),
    .freeze   (seq_freeze),
    .cnt      (seq_cnt),
    .zero     (seq_zero)
  );

  always_comb begin
    state_nxt     = state;
    mcnt_nxt      = '0;
    stop_pend_nxt = 1'b0;
    seq_load      = 1'b0;
    seq_load_val  = '0;
    seq_dec       = 1'b0;
    seq_freeze    = 1'b0;
    stall         = 1'b0;
    stall_fe      = 1'b0;
    bubble_ex     = 1'b0;
    rst_pipe      = 1'b0;
    pc_redirect   = 1'b0;
    trap_ack      = 1'b0;
    mem_tmo       = 1'b0;

    case (state)
      ST_HALT: begin
        stall = 1'b1;
        if (bus.cpu_start && !bus.cpu_stop) state_nxt = ST_RUN;
      end

      ST_RUN: begin
        case (req)
          REQ_STOP: state_nxt = ST_HALT;
          REQ_TRAP: begin
            state_nxt    = ST_DRAIN;
            seq_load     = 1'b1;
            seq_load_val = SEQ_CW'(DRAIN_CYC - 1);
          end
          REQ_JMP: begin
            // The redirect cycle itself is the first rst_pipe cycle.
            pc_redirect = 1'b1;
            rst_pipe    = 1'b1;
            if (FLUSH_CYC > 1) begin
              state_nxt    = ST_FLUSH;
              seq_load     = 1'b1;
              seq_load_val = SEQ_CW'(FLUSH_CYC - 1);
            end
          end
          REQ_MEM: begin
            stall     = 1'b1;
            mcnt_nxt  = mcnt_inc;
            state_nxt = ST_MWAIT;
          end
          REQ_LD: begin
            stall_fe  = 1'b1;
            bubble_ex = 1'b1;
            state_nxt = ST_LDSTL;
          end
          default: ;
        endcase
      end

      ST_LDSTL: state_nxt = ST_RUN;

      ST_MWAIT: begin
        if (bus.mem_wait) begin
          stall    = 1'b1;
          mcnt_nxt = mcnt_inc;
          mem_tmo  = (mcnt == MCNT_W'(MWAIT_MAX - 1));
        end else begin
          state_nxt = ST_RUN;
        end
      end

      ST_FLUSH: begin
        rst_pipe = 1'b1;
        seq_dec  = 1'b1;
        if (seq_zero || (seq_cnt == SEQ_CW'(1))) state_nxt = ST_RUN;
      end

      ST_DRAIN: begin
        stall_fe      = 1'b1;
        bubble_ex     = 1'b1;
        seq_dec       = 1'b1;
        stop_pend_nxt = stop_pend | bus.cpu_stop;
        if (bus.mem_wait) begin
          stall      = 1'b1;
          seq_freeze = 1'b1;
        end else if (seq_zero) begin
          stop_pend_nxt = 1'b0;
          if (stop_pend || bus.cpu_stop) begin
            state_nxt = ST_HALT;
          end else begin
            pc_redirect = 1'b1;
            trap_ack    = 1'b1;
            rst_pipe    = 1'b1;
            state_nxt   = ST_RUN;
          end
        end
      end

      default: state_nxt = ST_HALT;
    endcase
  end

  assign bus.stall       = stall;
  assign bus.stall_fe    = stall_fe;
  assign bus.bubble_ex   = bubble_ex;
  assign bus.rst_pipe    = rst_pipe;
  assign bus.pc_redirect = pc_redirect;
  assign bus.trap_ack    = trap_ack;
  assign bus.mem_tmo     = mem_tmo;
  assign bus.cpu_running = (state != ST_HALT);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: constant vector table, hand sequences, then random
// stimulus against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int FLUSH_CYC = 2;
  localparam int DRAIN_CYC = 3;
  localparam int MWAIT_MAX = 15;

  // input vector {cpu_start, cpu_stop, stall_ld, mem_wait, jmp_taken_ex, trap_req}
  localparam logic [5:0] I_NONE  = 6'b000000;
  localparam logic [5:0] I_START = 6'b100000;
  localparam logic [5:0] I_STOP  = 6'b010000;
  localparam logic [5:0] I_LD    = 6'b001000;
  localparam logic [5:0] I_MW    = 6'b000100;
  localparam logic [5:0] I_JMP   = 6'b000010;
  localparam logic [5:0] I_TRAP  = 6'b000001;

  // output vector {stall, stall_fe, bubble_ex, rst_pipe, pc_redirect, trap_ack, mem_tmo, cpu_running}
  localparam logic [7:0] O_HALT = 8'b1000_0000;
  localparam logic [7:0] O_RUN  = 8'b0000_0001;
  localparam logic [7:0] O_BUB  = 8'b0110_0001;
  localparam logic [7:0] O_JMP  = 8'b0001_1001;
  localparam logic [7:0] O_FL   = 8'b0001_0001;
  localparam logic [7:0] O_DFRZ = 8'b1110_0001;
  localparam logic [7:0] O_ACK  = 8'b0111_1101;
  localparam logic [7:0] O_MW   = 8'b1000_0001;
  localparam logic [7:0] O_TMO  = 8'b1000_0011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pipe_ctrl_if bus();

  pipe_ctrl #(.FLUSH_CYC(FLUSH_CYC), .DRAIN_CYC(DRAIN_CYC), .MWAIT_MAX(MWAIT_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [5:0] in;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  // behavioural model state
  bit m_halted;
  bit m_ld_skip;
  bit m_stop_seen;
  int m_waited;
  int m_flush_left;
  int m_drain_left;

  function automatic logic [7:0] outs();
    return {bus.stall, bus.stall_fe, bus.bubble_ex, bus.rst_pipe,
            bus.pc_redirect, bus.trap_ack, bus.mem_tmo, bus.cpu_running};
  endfunction

  function void add(input logic [5:0] v, input logic [7:0] e);
    vec_t r;
    r.in  = v;
    r.exp = e;
    tbl.push_back(r);
  endfunction

  task automatic drive(input logic [5:0] v);
    {bus.cpu_start, bus.cpu_stop, bus.stall_ld, bus.mem_wait, bus.jmp_taken_ex, bus.trap_req} = v;
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] exp);
    logic [7:0] got;
    got = outs();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got=%b exp=%b", name, idx, got, exp);
    end
  endtask

  task automatic step(input logic [5:0] v, input logic [7:0] exp, input string name, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    check(name, idx, exp);
  endtask

  task automatic do_reset();
    drive(I_NONE);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    m_halted     = 1'b1;
    m_ld_skip    = 1'b0;
    m_stop_seen  = 1'b0;
    m_waited     = 0;
    m_flush_left = 0;
    m_drain_left = 0;
  endtask

  // One clock of the rules: returns this cycle's outputs, advances to next cycle.
  task automatic model_step(input logic [5:0] v, output logic [7:0] e);
    bit st, sp, ld, mw, jp, tr;
    bit o_st, o_fe, o_bub, o_rst, o_red, o_ack, o_tmo, o_run;
    {st, sp, ld, mw, jp, tr} = v;
    {o_st, o_fe, o_bub, o_rst, o_red, o_ack, o_tmo} = '0;
    o_run = !m_halted;
    if (m_halted) begin
      o_st = 1;
      if (st && !sp) m_halted = 0;
    end else if (m_drain_left > 0) begin
      o_fe = 1;
      o_bub = 1;
      m_stop_seen = m_stop_seen | sp;
      if (mw) o_st = 1;
      else if (m_drain_left == 1) begin
        if (m_stop_seen) m_halted = 1;
        else {o_red, o_ack, o_rst} = 3'b111;
        m_drain_left = 0;
        m_stop_seen = 0;
      end else m_drain_left--;
    end else if (m_flush_left > 0) begin
      o_rst = 1;
      m_flush_left--;
    end else if (m_waited > 0) begin
      if (mw) begin
        o_st = 1;
        m_waited++;
        o_tmo = (m_waited == MWAIT_MAX);
      end else m_waited = 0;
    end else if (m_ld_skip) begin
      m_ld_skip = 0;
    end else begin
      if (sp) m_halted = 1;
      else if (tr) m_drain_left = DRAIN_CYC;
      else if (jp) begin
        o_red = 1;
        o_rst = 1;
        m_flush_left = FLUSH_CYC - 1;
      end else if (mw) begin
        o_st = 1;
        m_waited = 1;
      end else if (ld) begin
        o_fe = 1;
        o_bub = 1;
        m_ld_skip = 1;
      end
    end
    e = {o_st, o_fe, o_bub, o_rst, o_red, o_ack, o_tmo, o_run};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] v;
    logic [7:0] e;
    bit trap_pend;
    bit mw_lvl;

    // reset, start, load-use
    add(I_NONE,            O_HALT);
    add(I_START | I_STOP,  O_HALT);
    add(I_START,           O_HALT);
    add(I_NONE,            O_RUN);
    add(I_LD,              O_BUB);
    add(I_LD,              O_RUN);
    add(I_LD,              O_BUB);
    add(I_NONE,            O_RUN);
    // jump beats mem_wait and stall_ld
    add(I_JMP | I_MW | I_LD, O_JMP);
    add(I_MW | I_LD,       O_FL);
    add(I_NONE,            O_RUN);
    // trap with mem_wait freezing the 2nd drain cycle
    add(I_TRAP,            O_RUN);
    add(I_TRAP,            O_BUB);
    add(I_TRAP | I_MW,     O_DFRZ);
    add(I_TRAP | I_MW,     O_DFRZ);
    add(I_TRAP,            O_BUB);
    add(I_TRAP,            O_ACK);
    add(I_NONE,            O_RUN);
    // cpu_stop during drain: drain completes, HALT, no ack
    add(I_TRAP,            O_RUN);
    add(I_TRAP | I_STOP,   O_BUB);
    add(I_TRAP,            O_BUB);
    add(I_TRAP,            O_BUB);
    add(I_TRAP,            O_HALT);
    add(I_START,           O_HALT);
    // stop beats trap and jump
    add(I_STOP | I_TRAP | I_JMP, O_RUN);
    add(I_NONE,            O_HALT);
    add(I_START,           O_HALT);
    // trap beats jump; jump served after; trap in FLUSH deferred
    add(I_TRAP | I_JMP | I_MW, O_RUN);
    add(I_TRAP | I_JMP,    O_BUB);
    add(I_TRAP | I_JMP,    O_BUB);
    add(I_TRAP | I_JMP,    O_ACK);
    add(I_JMP,             O_JMP);
    add(I_TRAP,            O_FL);
    add(I_TRAP,            O_RUN);
    add(I_TRAP,            O_BUB);
    add(I_TRAP,            O_BUB);
    add(I_TRAP,            O_ACK);
    add(I_NONE,            O_RUN);
    // mem_wait beats stall_ld; jump held off in MWAIT
    add(I_MW | I_LD,       O_MW);
    add(I_MW | I_JMP,      O_MW);
    add(I_JMP,             O_RUN);
    add(I_JMP,             O_JMP);
    add(I_NONE,            O_FL);
    add(I_NONE,            O_RUN);

    do_reset();
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].in, tbl[i].exp, "tbl", i);

    // mem_wait held 17 cycles: stall throughout, mem_tmo only on the 15th
    for (int k = 1; k <= 17; k++)
      step(I_MW, (k == 15) ? O_TMO : O_MW, "mwait", k);
    step(I_LD, O_RUN, "mwait_exit", 18);
    step(I_LD, O_BUB, "mwait_run", 19);
    step(I_NONE, O_RUN, "ldstl", 20);

    // reset in the middle of a drain
    step(I_TRAP, O_RUN, "rst_drain", 0);
    step(I_TRAP, O_BUB, "rst_drain", 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 0, O_HALT);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++)
      step(I_TRAP, O_HALT, "rst_halt", k);

    // randomized run against the model
    do_reset();
    model_reset();
    trap_pend = 1'b0;
    mw_lvl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!trap_pend && ($urandom_range(0, 19) == 0)) trap_pend = 1'b1;
      if ($urandom_range(0, 3) == 0) mw_lvl = ~mw_lvl;
      v = {($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 2) == 0), mw_lvl,
           ($urandom_range(0, 5) == 0), trap_pend};
      @(negedge clk);
      drive(v);
      #1;
      model_step(v, e);
      check("rand", c, e);
      if (e[2]) trap_pend = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
